// File: rtl/cfo_est_if.sv
// Sample stream into the CFO estimator and frequency-word result out of it.
interface cfo_est_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned FW = 32
);
  logic                 val;
  logic signed [IW-1:0] i_i;
  logic signed [IW-1:0] q_i;
  logic signed [FW-1:0] freq_word_o;
  logic                 fw_val_o;
  logic                 busy_o;
  logic                 ovf_o;

  modport master (
    output val, i_i, q_i,
    input  freq_word_o, fw_val_o, busy_o, ovf_o
  );

  modport slave (
    input  val, i_i, q_i,
    output freq_word_o, fw_val_o, busy_o, ovf_o
  );
endinterface

// File: rtl/cfo_est.sv
// Carrier-frequency-offset estimator: averages lag-1 conjugate products over 2^AVG_LOG2
// samples and takes their angle with a vectoring CORDIC. 2^FW is one full turn (FW <= 32).
module cfo_est #(
  parameter int unsigned IW       = 16,
  parameter int unsigned FW       = 32,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned ITER     = 16
) (
  input logic      clk,
  input logic      rst,
  cfo_est_if.slave bus
);
  localparam int unsigned PW = 2 * IW + 1;
  localparam int unsigned AW = PW + AVG_LOG2;
  localparam int unsigned XW = AW + 2;
  localparam int unsigned CW = AVG_LOG2 + 1;
  localparam int unsigned KW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [CW-1:0] LastCnt     = CW'((1 << AVG_LOG2) - 1);
  localparam logic [KW-1:0] LastIt      = KW'(ITER - 1);
  localparam logic [FW-1:0] QuarterTurn = {2'b01, {(FW - 2){1'b0}}};
  localparam logic [FW-1:0] HalfTurn    = {1'b1, {(FW - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

  // atan(2^-k) in turns scaled by 2^32, rounded; rescaled to FW bits with rounding.
  function automatic logic [FW-1:0] atan_turns(input logic [4:0] k);
    logic [32:0] rom;
    logic [32:0] rnd;
    rom = '0;
    case (k)
      5'd0:  rom = 33'h020000000;
      5'd1:  rom = 33'h012E4051E;
      5'd2:  rom = 33'h009FB385B;
      5'd3:  rom = 33'h0051111D4;
      5'd4:  rom = 33'h0028B0D43;
      5'd5:  rom = 33'h00145D7E1;
      5'd6:  rom = 33'h000A2F61E;
      5'd7:  rom = 33'h000517C55;
      5'd8:  rom = 33'h00028BE53;
      5'd9:  rom = 33'h000145F2F;
      5'd10: rom = 33'h0000A2F98;
      5'd11: rom = 33'h0000517CC;
      5'd12: rom = 33'h000028BE6;
      5'd13: rom = 33'h0000145F3;
      5'd14: rom = 33'h000000A2FA;
      5'd15: rom = 33'h00000517D;
      5'd16: rom = 33'h0000028BE;
      5'd17: rom = 33'h00000145F;
      5'd18: rom = 33'h000000A30;
      5'd19: rom = 33'h000000518;
      5'd20: rom = 33'h00000028C;
      5'd21: rom = 33'h000000146;
      5'd22: rom = 33'h0000000A3;
      5'd23: rom = 33'h000000051;
      5'd24: rom = 33'h000000029;
      5'd25: rom = 33'h000000014;
      5'd26: rom = 33'h00000000A;
      5'd27: rom = 33'h000000005;
      5'd28: rom = 33'h000000003;
      5'd29: rom = 33'h000000001;
      5'd30: rom = 33'h000000001;
      default: rom = '0;
    endcase
    rnd = (33'd1 << (32 - FW)) >> 1;
    rom = (rom + rnd) >> (32 - FW);
    return rom[FW-1:0];
  endfunction

  // Sample stage and lag-1 conjugate product.
  logic signed [IW-1:0] ip_q, qp_q;
  logic                 prev_vld_q;
  logic signed [PW-1:0] i_x, q_x, ip_x, qp_x;
  logic signed [PW-1:0] prod_re, prod_im;

  assign i_x  = {{(PW - IW){bus.i_i[IW-1]}}, bus.i_i};
  assign q_x  = {{(PW - IW){bus.q_i[IW-1]}}, bus.q_i};
  assign ip_x = {{(PW - IW){ip_q[IW-1]}}, ip_q};
  assign qp_x = {{(PW - IW){qp_q[IW-1]}}, qp_q};

  assign prod_re = i_x * ip_x + q_x * qp_x;
  assign prod_im = q_x * ip_x - i_x * qp_x;

  // Window accumulator.
  logic signed [AW-1:0] acc_re_q, acc_im_q;
  logic signed [AW-1:0] sum_re, sum_im;
  logic [CW-1:0]        cnt_q;
  logic                 prod_v;
  logic                 win_done;

  assign prod_v   = bus.val & prev_vld_q;
  assign sum_re   = acc_re_q + {{(AW - PW){prod_re[PW-1]}}, prod_re};
  assign sum_im   = acc_im_q + {{(AW - PW){prod_im[PW-1]}}, prod_im};
  assign win_done = prod_v && (cnt_q == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_q       <= '0;
      qp_q       <= '0;
      prev_vld_q <= 1'b0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      cnt_q      <= '0;
    end else if (bus.val) begin
      ip_q       <= bus.i_i;
      qp_q       <= bus.q_i;
      prev_vld_q <= 1'b1;
      if (prev_vld_q) begin
        if (win_done) begin
          acc_re_q <= '0;
          acc_im_q <= '0;
          cnt_q    <= '0;
        end else begin
          acc_re_q <= sum_re;
          acc_im_q <= sum_im;
          cnt_q    <= cnt_q + CW'(1);
        end
      end
    end
  end

  // CORDIC control and datapath.
  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [XW-1:0] x_sh, y_sh;
  logic [FW-1:0]        z_q, z_d;
  logic [FW-1:0]        atan_k;
  logic [KW-1:0]        it_q, it_d;
  logic [FW-1:0]        freq_q, freq_d;
  logic                 fw_val_q, fw_val_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    it_d     = it_q;
    freq_d   = freq_q;
    fw_val_d = 1'b0;
    ovf_d    = win_done && (state_q != StIdle);
    x_sh     = x_q >>> it_q;
    y_sh     = y_q >>> it_q;
    atan_k   = atan_turns(5'(it_q));

    unique case (state_q)
      StIdle: begin
        if (win_done) begin
          x_d     = {{2{sum_re[AW-1]}}, sum_re};
          y_d     = {{2{sum_im[AW-1]}}, sum_im};
          z_d     = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        it_d    = '0;
        state_d = StIter;
        if (x_q[XW-1]) begin
          // Negative real axis maps straight to a half turn so pi comes out exact.
          if (y_q == '0) begin
            x_d = -x_q;
            z_d = HalfTurn;
          end else if (!y_q[XW-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = QuarterTurn;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = -QuarterTurn;
          end
        end
      end
      StIter: begin
        if (y_q[XW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_k;
        end else if (y_q != '0) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_k;
        end
        it_d = it_q + KW'(1);
        if (it_q == LastIt) begin
          state_d  = StDone;
          freq_d   = z_d;
          fw_val_d = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      it_q     <= '0;
      freq_q   <= '0;
      fw_val_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      it_q     <= it_d;
      freq_q   <= freq_d;
      fw_val_q <= fw_val_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.freq_word_o = freq_q;
  assign bus.fw_val_o    = fw_val_q;
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_cfo_est.sv
// Scoreboard bench for cfo_est: an 8-product instance and a 2-product overflow instance.
module tb_cfo_est;
  localparam int unsigned IW   = 16;
  localparam int unsigned FW   = 32;
  localparam int unsigned ITER = 16;
  localparam int          LAT  = ITER + 2;
  localparam int          TOL  = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cfo_est_if #(.IW(IW), .FW(FW)) bus_a ();
  cfo_est_if #(.IW(IW), .FW(FW)) bus_b ();

  cfo_est #(.IW(IW), .FW(FW), .AVG_LOG2(3), .ITER(ITER)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  cfo_est #(.IW(IW), .FW(FW), .AVG_LOG2(1), .ITER(ITER)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    longint freq;
    int     tol;
    int     cyc;
  } exp_t;

  exp_t   exp_q_a[$];
  exp_t   exp_q_b[$];
  int     ovf_q_a[$];
  int     ovf_q_b[$];
  int     cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  int     prod_cnt[2];
  bit     prev_m[2];
  int     last_acc[2];
  longint cur_freq;
  int     cur_tol;

  int p45_i[8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
  int p45_q[8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};
  int p90_i[4] = '{32767, 0, -32768, 0};
  int p90_q[4] = '{0, 32767, 0, -32768};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint exp,
                           input int tol = 0);
    int d;
    n_chk++;
    d = int'(got - exp);  // modulo 2^32, so frequency-word wrap compares correctly
    if (d >= -tol && d <= tol) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (tol %0d)", tag, got, exp, tol);
  endtask

  task automatic clear_model();
    exp_q_a.delete();
    exp_q_b.delete();
    ovf_q_a.delete();
    ovf_q_b.delete();
    for (int k = 0; k < 2; k++) begin
      prod_cnt[k] = 0;
      prev_m[k]   = 1'b0;
      last_acc[k] = -1000;
    end
  endtask

  // Present one sample for one cycle (called just after a negedge), then idle gap cycles.
  task automatic send(input bit sel, input int si, input int sq, input int gap);
    int k;
    int n;
    k = sel ? 1 : 0;
    n = sel ? 2 : 8;
    if (sel) begin
      bus_b.val = 1'b1;
      bus_b.i_i = 16'(si);
      bus_b.q_i = 16'(sq);
    end else begin
      bus_a.val = 1'b1;
      bus_a.i_i = 16'(si);
      bus_a.q_i = 16'(sq);
    end
    if (prev_m[k]) begin
      prod_cnt[k]++;
      if (prod_cnt[k] == n) begin
        prod_cnt[k] = 0;
        if (cyc - last_acc[k] > LAT) begin
          last_acc[k] = cyc;
          if (sel) exp_q_b.push_back('{cur_freq, cur_tol, cyc});
          else exp_q_a.push_back('{cur_freq, cur_tol, cyc});
        end else if (sel) begin
          ovf_q_b.push_back(cyc + 1);
        end else begin
          ovf_q_a.push_back(cyc + 1);
        end
      end
    end
    prev_m[k] = 1'b1;
    @(negedge clk);
    bus_a.val = 1'b0;
    bus_b.val = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q_a.size() + exp_q_b.size() + ovf_q_a.size() + ovf_q_b.size()) != 0 &&
           t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_pending"},
              exp_q_a.size() + exp_q_b.size() + ovf_q_a.size() + ovf_q_b.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus_a.fw_val_o) begin
        if (exp_q_a.size() == 0) check_val("a_fw_spurious", longint'(bus_a.fw_val_o), 0);
        else begin
          e = exp_q_a.pop_front();
          check_val("a_freq", longint'(bus_a.freq_word_o), e.freq, e.tol);
          check_val("a_latency", cyc - e.cyc, LAT);
        end
      end
      if (bus_a.ovf_o) begin
        if (ovf_q_a.size() == 0) check_val("a_ovf_spurious", longint'(bus_a.ovf_o), 0);
        else check_val("a_ovf_cycle", cyc, ovf_q_a.pop_front());
      end
      if (bus_b.fw_val_o) begin
        if (exp_q_b.size() == 0) check_val("b_fw_spurious", longint'(bus_b.fw_val_o), 0);
        else begin
          e = exp_q_b.pop_front();
          check_val("b_freq", longint'(bus_b.freq_word_o), e.freq, e.tol);
          check_val("b_latency", cyc - e.cyc, LAT);
        end
      end
      if (bus_b.ovf_o) begin
        if (ovf_q_b.size() == 0) check_val("b_ovf_spurious", longint'(bus_b.ovf_o), 0);
        else check_val("b_ovf_cycle", cyc, ovf_q_b.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.val = 1'b0;
    bus_a.i_i = '0;
    bus_a.q_i = '0;
    bus_b.val = 1'b0;
    bus_b.i_i = '0;
    bus_b.q_i = '0;
    cur_freq  = 0;
    cur_tol   = 0;
    clear_model();

    #1 rst = 1'b1;
    #1;
    check_val("rst_freq", longint'(bus_a.freq_word_o), 0);
    check_val("rst_fw_val", longint'(bus_a.fw_val_o), 0);
    check_val("rst_busy", longint'(bus_a.busy_o), 0);
    check_val("rst_ovf", longint'(bus_a.ovf_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Constant phasor: zero rotation.
    cur_freq = 0;
    cur_tol  = TOL;
    for (int n = 0; n < 9; n++) send(1'b0, 32767, 0, 0);
    drain("const");

    // 45 deg/sample counter-clockwise.
    pulse_reset();
    cur_freq = 64'h2000_0000;
    for (int n = 0; n < 9; n++) send(1'b0, p45_i[n % 8], p45_q[n % 8], 0);
    check_val("busy_active", longint'(bus_a.busy_o), 1);
    drain("ccw45");
    check_val("busy_idle", longint'(bus_a.busy_o), 0);

    // 45 deg/sample clockwise.
    pulse_reset();
    cur_freq = 64'hE000_0000;
    for (int n = 0; n < 9; n++) send(1'b0, p45_i[n % 8], -p45_q[n % 8], 0);
    drain("cw45");

    // 90 deg/sample.
    pulse_reset();
    cur_freq = 64'h4000_0000;
    for (int n = 0; n < 9; n++) send(1'b0, p90_i[n % 4], p90_q[n % 4], 0);
    drain("ccw90");

    // 180 deg/sample must be exact.
    pulse_reset();
    cur_freq = 64'h8000_0000;
    cur_tol  = 0;
    for (int n = 0; n < 9; n++) send(1'b0, (n % 2 == 0) ? 32767 : -32767, 0, 0);
    drain("pi");

    // 45 deg/sample with val one cycle in three.
    pulse_reset();
    cur_freq = 64'h2000_0000;
    cur_tol  = TOL;
    for (int n = 0; n < 9; n++) send(1'b0, p45_i[n % 8], p45_q[n % 8], 2);
    drain("gapped45");

    // Window in flight, then reset during the CORDIC run.
    for (int n = 9; n < 17; n++) send(1'b0, p45_i[n % 8], p45_q[n % 8], 0);
    repeat (5) @(negedge clk);
    check_val("mid_busy", longint'(bus_a.busy_o), 1);
    rst = 1'b1;
    clear_model();
    #1;
    check_val("mid_rst_freq", longint'(bus_a.freq_word_o), 0);
    check_val("mid_rst_fw_val", longint'(bus_a.fw_val_o), 0);
    check_val("mid_rst_busy", longint'(bus_a.busy_o), 0);
    check_val("mid_rst_ovf", longint'(bus_a.ovf_o), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    cur_freq = 64'h4000_0000;
    for (int n = 0; n < 9; n++) send(1'b0, p90_i[n % 4], p90_q[n % 4], 0);
    drain("post_rst");

    // Short windows under continuous val: overflow while the CORDIC is busy.
    pulse_reset();
    cur_freq = 64'h2000_0000;
    for (int n = 0; n < 40; n++) send(1'b1, p45_i[n % 8], p45_q[n % 8], 0);
    drain("ovf");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cfo_est.md
Name: cfo_est

Overview:
- Carrier-frequency-offset estimator: the receiving end of the CFO test-pattern generator.
- Consumes a stream of complex baseband samples (I/Q) qualified by val.
- Computes the per-sample phase advance by averaging the lag-1 conjugate products x[n]·conj(x[n-1]) over a window and taking the angle with an iterative CORDIC.
- Emits a signed frequency word to the NCO/derotator in the MSK demod chain, scaled so 2^FW equals 2π rad/sample.

Parameters:
- IW, 16, input I/Q width (signed).
- FW, 32, frequency word width; 2^FW equals 2π rad/sample.
- AVG_LOG2, 3, window length N = 2^AVG_LOG2 products per estimate (1..8).
- ITER, 16, CORDIC vectoring iterations (8..FW-2).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- val, input, 1, i_i/q_i valid this cycle.
- i_i, input, IW, signed in-phase sample.
- q_i, input, IW, signed quadrature sample.
- freq_word_o, output, FW, signed per-sample phase advance estimate.
- fw_val_o, output, 1, one-cycle pulse: freq_word_o updated.
- busy_o, output, 1, CORDIC computing.
- ovf_o, output, 1, one-cycle pulse: a completed window was dropped because the CORDIC was busy.

Behaviour:
- Reset, asynchronous and active-high, clears:
  - freq_word_o=0, fw_val_o=0, busy_o=0, ovf_o=0.
  - prev-sample valid flag, accumulators, product counter.
  - FSM returns to IDLE.
- Reset asserted mid-window or mid-CORDIC discards all partial state; no output pulse is produced for that window.
- Sample stage, on each val:
  - The sample is stored as prev; prev_vld is set.
  - If prev_vld was already 1, a product is formed:
    - re = i·ip + q·qp
    - im = q·ip − i·qp
    - Width 2·IW+1, full precision, no rounding.
  - The first val after reset produces no product.
- Accumulator:
  - Sums re and im separately over N products.
  - Width 2·IW+1+AVG_LOG2; saturation is impossible.
  - Cycles with val=0 hold all state.
- Window complete, on the cycle the N-th product is accumulated (cycle t):
  - If FSM is IDLE: sums are latched into the CORDIC x/y registers, accumulators restart at 0 with the next product, FSM goes to LOAD at t+1.
  - If FSM is not IDLE: the window is discarded, accumulators restart, ovf_o pulses at t+1.
- FSM states:
  - IDLE: waiting for a completed window; busy_o=0.
  - LOAD (1 cycle): quadrant pre-rotation.
    - If x<0, rotate by ±π/2: y≥0 → +π/2, y<0 → −π/2.
    - x, y are sign-extended by 2 bits for CORDIC gain growth.
  - ITER (ITER cycles): standard vectoring.
    - d = −sign(y)
    - x ← x − d·(y>>>k)
    - y ← y + d·(x>>>k)
    - z ← z − d·atan(2^-k) for k = 0..ITER−1.
    - The atan table is an FW-bit constant ROM in turns·2^FW, rounded to nearest.
  - DONE (1 cycle): freq_word_o ← z; fw_val_o=1 at this cycle's edge.
  - Then IDLE. busy_o=1 in LOAD, ITER and DONE.
- Latency: fw_val_o asserts at cycle t+ITER+2 relative to the window-complete cycle t.
- Output scaling: freq_word_o is the angle of the summed product, i.e. the mean per-sample rotation. It is not divided by N.
- Boundaries:
  - Exact π (x<0, y=0) → 0x8000_0000 (for FW=32).
  - Zero vector (x=y=0) → 0.
  - z wraps modulo 2^FW.
- freq_word_o holds its value between updates.

Test Plan:
- Constant (0x7FFF, 0) samples, continuous val, 9 samples → one fw_val_o pulse, freq_word_o = 0x0000_0000 ±0x0002_0000, ovf_o never asserts.
- 8-phase CCW phasor, 45°/sample: (32767,0), (23170,23170), (0,32767), … continuous → freq_word_o = 0x2000_0000 ±0x0002_0000; fw_val_o exactly ITER+2 cycles after the 9th val.
- Same pattern with Q negated (CW rotation) → freq_word_o = 0xE000_0000 ±0x0002_0000.
- 90°/sample sequence (0x7FFF,0), (0,0x7FFF), (0x8000,0), (0,0x8000) → 0x4000_0000 ±0x0002_0000. 180°/sample (alternating ±0x7FFF on I) → exactly 0x8000_0000.
- val toggling 1-in-3 cycles with the 45° pattern → same result as continuous. Then with AVG_LOG2=1 and ITER=16 under continuous val → ovf_o pulses for windows completing while busy_o=1, and freq_word_o stays correct.
- Assert rst for one cycle mid-ITER → all outputs 0 immediately, no fw_val_o for that window. The next result requires N+1 fresh samples.
